// File: rtl/apb_prio_irq_cntrl.sv
// apb_prio_irq_cntrl: APB-programmed priority interrupt controller with event FIFO; IRQ_EDGE_DETECT_EN selects edge-triggered lines
module apb_prio_irq_cntrl #(
  parameter int NUM_IRQ      = 32,
  parameter int FIFO_IRQ     = 26,
  parameter int EVT_ID_WIDTH = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int PRIO_WIDTH   = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NUM_IRQ-1:0]      events_i,
  input  logic                    evt_valid_i,
  input  logic [EVT_ID_WIDTH-1:0] evt_data_i,
  output logic                    evt_ready_o,
  output logic                    core_irq_req_o,
  output logic [4:0]              core_irq_id_o,
  input  logic                    core_irq_ack_i,
  input  logic [4:0]              core_irq_id_i,
  input  logic                    psel_i,
  input  logic                    penable_i,
  input  logic                    pwrite_i,
  input  logic [11:0]             paddr_i,
  input  logic [31:0]             pwdata_i,
  output logic [31:0]             prdata_o,
  output logic                    pready_o,
  output logic                    pslverr_o
);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int NPR = (NUM_IRQ + 7) / 8;
  localparam logic [NUM_IRQ-1:0] FBIT = NUM_IRQ'(1) << FIFO_IRQ;

  logic [NUM_IRQ-1:0]      mask_q, mask_d, pend_q, pend_d, ack_q, ack_d, pending, evt_set, wd;
  logic [PRIO_WIDTH-1:0]   prio_q [NUM_IRQ];
  logic [PRIO_WIDTH-1:0]   prio_d [NUM_IRQ];
  logic [PRIO_WIDTH-1:0]   thresh_q, thresh_d, best_p;
  logic [EVT_ID_WIDTH-1:0] fifo_q [FIFO_DEPTH];
  logic [EVT_ID_WIDTH-1:0] fifo_d [FIFO_DEPTH];
  logic [EVT_ID_WIDTH-1:0] fdata_q, fdata_d;
  logic [AW-1:0]           wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]             cnt_q, cnt_d;
  logic                    ovf_q, ovf_d, req_q, req_d, found;
  logic [4:0]              id_q, id_d, best_i;
  logic [31:0]             widx, rdata;
  logic                    access, wr, rd, is_prio, mapped, full, empty, ack_ok, pop, push;
  logic                    unused_addr;

  assign unused_addr = ^paddr_i[1:0];
  assign widx    = 32'(paddr_i[11:2]);
  assign access  = psel_i & penable_i;
  assign wr      = access & pwrite_i;
  assign rd      = access & ~pwrite_i;
  assign is_prio = widx >= 32'd16 && widx < 32'(16 + NPR);
  assign mapped  = widx <= 32'd10 || is_prio;
  assign wd      = pwdata_i[NUM_IRQ-1:0];

  assign full    = cnt_q == (AW+1)'(FIFO_DEPTH);
  assign empty   = cnt_q == '0;
  assign ack_ok  = core_irq_ack_i && 32'(core_irq_id_i) < NUM_IRQ;
  assign pop     = ack_ok && 32'(core_irq_id_i) == FIFO_IRQ && !empty;
  assign push    = evt_valid_i && (!full || pop);
  assign pending = (pend_q & ~FBIT) | (empty ? '0 : FBIT);

  assign evt_ready_o    = !full;
  assign core_irq_req_o = req_q;
  assign core_irq_id_o  = id_q;
  assign pready_o       = 1'b1;
  assign pslverr_o      = access & !mapped;

`ifdef IRQ_EDGE_DETECT_EN
  logic [NUM_IRQ-1:0] evt_q, evt_dly_q;
  // register the raw lines and fire only on their rising edge
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      evt_q     <= '0;
      evt_dly_q <= '0;
    end else begin
      evt_q     <= events_i;
      evt_dly_q <= evt_q;
    end
  end
  assign evt_set = evt_q & ~evt_dly_q;
`else
  assign evt_set = events_i;
`endif

  // register writes, acknowledge and event capture; events are applied last so they win over clears
  always_comb begin
    mask_d   = mask_q;
    pend_d   = pend_q;
    ack_d    = ack_q;
    thresh_d = thresh_q;
    prio_d   = prio_q;
    ovf_d    = ovf_q;
    if (wr && widx == 32'd0) mask_d = wd;
    if (wr && widx == 32'd1) mask_d = mask_q | wd;
    if (wr && widx == 32'd2) mask_d = mask_q & ~wd;
    if (wr && widx == 32'd3) pend_d = wd;
    if (wr && widx == 32'd4) pend_d = pend_q | wd;
    if (wr && widx == 32'd5) pend_d = pend_q & ~wd;
    if (wr && widx == 32'd6) ack_d = wd;
    if (wr && widx == 32'd7) ack_d = ack_q & ~wd;
    if (wr && widx == 32'd9) thresh_d = pwdata_i[PRIO_WIDTH-1:0];
    if (wr && widx == 32'd10 && pwdata_i[16]) ovf_d = 1'b0;
    if (evt_valid_i && full && !pop) ovf_d = 1'b1;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (wr && widx == 32'(16 + i / 8)) prio_d[i] = pwdata_i[4*(i%8) +: PRIO_WIDTH];
      if (ack_ok && 32'(core_irq_id_i) == i) begin
        pend_d[i] = 1'b0;
        ack_d[i]  = 1'b1;
      end
    end
    pend_d = (pend_d | evt_set) & ~FBIT;
  end

  // event FIFO: pop into FIFO_DATA on ack of its line, push behind it in the same cycle
  always_comb begin
    fifo_d  = fifo_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    fdata_d = fdata_q;
    if (pop) begin
      fdata_d = fifo_q[rptr_q];
      rptr_d  = rptr_q + AW'(1);
    end
    if (push) begin
      fifo_d[wptr_q] = evt_data_i;
      wptr_d         = wptr_q + AW'(1);
    end
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  // pick the most urgent eligible line; strict compare keeps the lowest index on ties
  always_comb begin
    found  = 1'b0;
    best_p = '0;
    best_i = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (pending[i] && mask_q[i] && prio_q[i] >= thresh_q && (!found || prio_q[i] > best_p)) begin
        found  = 1'b1;
        best_p = prio_q[i];
        best_i = 5'(i);
      end
    end
    req_d = found;
    id_d  = found ? best_i : id_q;
  end

  // APB read mux, zero outside a valid access phase
  always_comb begin
    rdata = '0;
    if (widx == 32'd0) rdata = 32'(mask_q);
    if (widx == 32'd3) rdata = 32'(pending);
    if (widx == 32'd6) rdata = 32'(ack_q);
    if (widx == 32'd8) rdata = 32'(fdata_q);
    if (widx == 32'd9) rdata = 32'(thresh_q);
    if (widx == 32'd10) rdata = {15'b0, ovf_q, 8'b0, 8'(cnt_q)};
    for (int i = 0; i < NUM_IRQ; i++)
      if (widx == 32'(16 + i / 8)) rdata[4*(i%8) +: PRIO_WIDTH] = prio_q[i];
    prdata_o = (rd && mapped) ? rdata : '0;
  end

  // state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mask_q   <= '0;
      pend_q   <= '0;
      ack_q    <= '0;
      thresh_q <= '0;
      for (int i = 0; i < NUM_IRQ; i++) prio_q[i] <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      fdata_q  <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      req_q    <= 1'b0;
      id_q     <= '0;
    end else begin
      mask_q   <= mask_d;
      pend_q   <= pend_d;
      ack_q    <= ack_d;
      thresh_q <= thresh_d;
      prio_q   <= prio_d;
      fifo_q   <= fifo_d;
      fdata_q  <= fdata_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      req_q    <= req_d;
      id_q     <= id_d;
    end
  end
endmodule

// File: tb/tb_apb_prio_irq_cntrl.sv
// tb_apb_prio_irq_cntrl: directed self-checking bench for apb_prio_irq_cntrl
module tb_apb_prio_irq_cntrl;
  logic        clk_i = 0, rst_ni = 0;
  logic [31:0] events_i = 0;
  logic        evt_valid_i = 0;
  logic [7:0]  evt_data_i = 0;
  logic        evt_ready_o, core_irq_req_o, core_irq_ack_i = 0;
  logic [4:0]  core_irq_id_o, core_irq_id_i = 0;
  logic        psel_i = 0, penable_i = 0, pwrite_i = 0;
  logic [11:0] paddr_i = 0;
  logic [31:0] pwdata_i = 0, prdata_o, rv;
  logic        pready_o, pslverr_o;
  int          n_run = 0, n_fail = 0;
  logic [7:0]  vals [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
  logic [7:0]  drain [4] = '{8'h33, 8'h44, 8'h66, 8'h77};

  apb_prio_irq_cntrl dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .events_i(events_i),
    .evt_valid_i(evt_valid_i), .evt_data_i(evt_data_i), .evt_ready_o(evt_ready_o),
    .core_irq_req_o(core_irq_req_o), .core_irq_id_o(core_irq_id_o),
    .core_irq_ack_i(core_irq_ack_i), .core_irq_id_i(core_irq_id_i),
    .psel_i(psel_i), .penable_i(penable_i), .pwrite_i(pwrite_i), .paddr_i(paddr_i),
    .pwdata_i(pwdata_i), .prdata_o(prdata_o), .pready_o(pready_o), .pslverr_o(pslverr_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apb_wr(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk_i);
    psel_i = 1; pwrite_i = 1; paddr_i = a; pwdata_i = d; penable_i = 0;
    @(negedge clk_i);
    penable_i = 1;
    @(negedge clk_i);
    psel_i = 0; penable_i = 0; pwrite_i = 0;
  endtask

  task automatic apb_rd(input logic [11:0] a, output logic [31:0] d);
    @(negedge clk_i);
    psel_i = 1; pwrite_i = 0; paddr_i = a; penable_i = 0;
    @(negedge clk_i);
    penable_i = 1;
    #1 d = prdata_o;
    @(negedge clk_i);
    psel_i = 0; penable_i = 0;
  endtask

  task automatic ack(input logic [4:0] id);
    @(negedge clk_i);
    core_irq_ack_i = 1; core_irq_id_i = id;
    @(negedge clk_i);
    core_irq_ack_i = 0;
  endtask

  initial begin
    #3;
    check("rst_req", 32'(core_irq_req_o), 0);
    check("rst_id", 32'(core_irq_id_o), 0);
    check("rst_ready", 32'(evt_ready_o), 1);
    check("rst_prdata", prdata_o, 0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1;
    // single-cycle event on line 5 reaches the pins two edges later
    apb_wr(12'h000, 32'hFFFF_FFFF);
    events_i = 32'h20;
    @(negedge clk_i);
    events_i = 0;
    check("t1_req_early", 32'(core_irq_req_o), 0);
    @(negedge clk_i);
`ifdef IRQ_EDGE_DETECT_EN
    @(negedge clk_i);
`endif
    check("t1_req", 32'(core_irq_req_o), 1);
    check("t1_id", 32'(core_irq_id_o), 5);
    apb_wr(12'h014, 32'h20);
    @(negedge clk_i);
    check("t1_clr_req", 32'(core_irq_req_o), 0);
    // priority and threshold
    apb_wr(12'h040, 32'h2000);
    apb_wr(12'h044, 32'h50);
    apb_wr(12'h010, 32'h208);
    @(negedge clk_i);
    check("t2_req", 32'(core_irq_req_o), 1);
    check("t2_id9", 32'(core_irq_id_o), 9);
    apb_wr(12'h024, 6);
    @(negedge clk_i);
    check("t2_thr_req", 32'(core_irq_req_o), 0);
    check("t2_id_held", 32'(core_irq_id_o), 9);
    apb_wr(12'h024, 0);
    apb_wr(12'h040, 32'h5000);
    @(negedge clk_i);
    check("t2_tie_id3", 32'(core_irq_id_o), 3);
    // ack racing with a fresh event on the same line
    @(negedge clk_i);
    events_i = 32'h200; core_irq_ack_i = 1; core_irq_id_i = 9;
    @(negedge clk_i);
    events_i = 0; core_irq_ack_i = 0;
    apb_rd(12'h00C, rv); check("t3_int", rv, 32'h208);
    apb_rd(12'h018, rv); check("t3_ack", rv, 32'h200);
    apb_wr(12'h01C, 32'h200);
    apb_rd(12'h018, rv); check("t3_ack_clr", rv, 0);
    ack(3);
    apb_rd(12'h00C, rv); check("t3_ack3", rv, 32'h200);
    apb_wr(12'h014, 32'h200);
    apb_rd(12'h00C, rv); check("t3_int_clr", rv, 0);
    // event FIFO fill and overflow
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      if (k == 3) check("t4_ready3", 32'(evt_ready_o), 1);
      if (k == 4) check("t4_full", 32'(evt_ready_o), 0);
      evt_valid_i = 1; evt_data_i = vals[k];
    end
    @(negedge clk_i);
    evt_valid_i = 0;
    apb_rd(12'h028, rv); check("t4_status", rv, 32'h1_0004);
    apb_rd(12'h00C, rv); check("t4_int26", rv, 32'h0400_0000);
    check("t4_id26", 32'(core_irq_id_o), 26);
    apb_wr(12'h00C, 0);
    apb_rd(12'h00C, rv); check("t4_int_wr_keep26", rv, 32'h0400_0000);
    ack(26);
    apb_rd(12'h020, rv); check("t4_pop", rv, 32'h11);
    apb_rd(12'h028, rv); check("t4_cnt3", rv, 32'h1_0003);
    apb_wr(12'h028, 32'h1_0000);
    apb_rd(12'h028, rv); check("t4_ovf_clr", rv, 3);
    @(negedge clk_i);
    evt_valid_i = 1; evt_data_i = 8'h66;
    @(negedge clk_i);
    evt_valid_i = 0;
    check("t4_full2", 32'(evt_ready_o), 0);
    evt_valid_i = 1; evt_data_i = 8'h77; core_irq_ack_i = 1; core_irq_id_i = 26;
    @(negedge clk_i);
    evt_valid_i = 0; core_irq_ack_i = 0;
    apb_rd(12'h028, rv); check("t4_pushpop", rv, 4);
    apb_rd(12'h020, rv); check("t4_pop22", rv, 32'h22);
    for (int j = 0; j < 4; j++) begin
      ack(26);
      apb_rd(12'h020, rv); check($sformatf("t4_drain%0d", j), rv, 32'(drain[j]));
    end
    apb_rd(12'h028, rv); check("t4_empty", rv, 0);
    check("t4_req_off", 32'(core_irq_req_o), 0);
    // slave error and access-phase gating of read data
    @(negedge clk_i);
    psel_i = 1; pwrite_i = 0; paddr_i = 12'h03C; penable_i = 0;
    #1 check("t5_setup_err", 32'(pslverr_o), 0);
    @(negedge clk_i);
    penable_i = 1;
    #1 check("t5_err", 32'(pslverr_o), 1);
    check("t5_err_data", prdata_o, 0);
    check("t5_ready", 32'(pready_o), 1);
    @(negedge clk_i);
    paddr_i = 12'h000; penable_i = 0;
    #1 check("t5_setup_data", prdata_o, 0);
    @(negedge clk_i);
    penable_i = 1;
    #1 check("t5_mask_rd", prdata_o, 32'hFFFF_FFFF);
    check("t5_ok", 32'(pslverr_o), 0);
    @(negedge clk_i);
    psel_i = 0; penable_i = 0;
    apb_wr(12'h048, 32'hFFFF_FFFF);
    apb_rd(12'h048, rv); check("t5_prio_trunc", rv, 32'h7777_7777);
    apb_rd(12'h040, rv); check("t5_prio0", rv, 32'h5000);
    apb_wr(12'h024, 32'hFF);
    apb_rd(12'h024, rv); check("t5_thresh", rv, 7);
    apb_wr(12'h024, 0);
    // held-high line acked once
    @(negedge clk_i);
    events_i = 32'h4;
    repeat (4) @(negedge clk_i);
    ack(2);
    repeat (5) @(negedge clk_i);
    events_i = 0;
    apb_rd(12'h00C, rv);
`ifdef IRQ_EDGE_DETECT_EN
    check("t6_edge_pend", rv, 0);
`else
    check("t6_level_pend", rv, 32'h4);
`endif
    apb_rd(12'h018, rv); check("t6_ack2", rv & 32'h4, 32'h4);
    // asynchronous reset mid-operation
    apb_wr(12'h014, 32'hFFFF_FFFF);
    apb_wr(12'h010, 32'h1);
    @(negedge clk_i);
    evt_valid_i = 1; evt_data_i = 8'h99;
    @(negedge clk_i);
    evt_valid_i = 0;
    check("t7_pre_req", 32'(core_irq_req_o), 1);
    #2 rst_ni = 0;
    #1 check("t7_async_req", 32'(core_irq_req_o), 0);
    check("t7_async_ready", 32'(evt_ready_o), 1);
    @(negedge clk_i);
    rst_ni = 1;
    apb_rd(12'h00C, rv); check("t7_int", rv, 0);
    apb_rd(12'h028, rv); check("t7_status", rv, 0);
    apb_rd(12'h000, rv); check("t7_mask", rv, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
